// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module      : if_fetch_stage
// Description : Fetch-stage controller: PC, imem address, IF/ID register,
//               fetch/miss performance counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    input  logic             imem_ready,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_instr,
    output logic             id_valid,
    output logic             fetch_stall,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam logic [31:0] C_PC_STEP = 32'd4;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic [31:0]      id_instr_q, id_instr_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic [31:0]      w_pc_plus4;

    assign w_pc_plus4 = pc_q + C_PC_STEP;

    // Priority: branch redirect > hazard freeze > memory miss > advance.
    always_comb begin
        pc_d          = pc_q;
        id_pc_d       = id_pc_q;
        id_instr_d    = id_instr_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;
        miss_count_d  = miss_count_q;
        if (branch_taken) begin
            pc_d       = {branch_addr[31:2], 2'b00};
            id_pc_d    = 32'd0;
            id_instr_d = 32'd0;
            id_valid_d = 1'b0;
        end else if (freeze) begin
            pc_d = pc_q;
        end else if (!imem_ready) begin
            id_pc_d      = 32'd0;
            id_instr_d   = 32'd0;
            id_valid_d   = 1'b0;
            miss_count_d = miss_count_q + CNT_W'(1);
        end else begin
            pc_d          = w_pc_plus4;
            id_pc_d       = w_pc_plus4;
            id_instr_d    = imem_instr;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= {RESET_PC[31:2], 2'b00};
            id_pc_q       <= 32'd0;
            id_instr_q    <= 32'd0;
            id_valid_q    <= 1'b0;
            fetch_count_q <= '0;
            miss_count_q  <= '0;
        end else begin
            pc_q          <= pc_d;
            id_pc_q       <= id_pc_d;
            id_instr_q    <= id_instr_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
            miss_count_q  <= miss_count_d;
        end
    end

    assign imem_addr   = {pc_q[31:2], 2'b00};
    assign fetch_stall = ~imem_ready;
    assign id_pc       = id_pc_q;
    assign id_instr    = id_instr_q;
    assign id_valid    = id_valid_q;
    assign fetch_count = fetch_count_q;
    assign miss_count  = miss_count_q;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Scoreboard bench for if_fetch_stage with directed vectors.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             freeze = 1'b0;
    logic             branch_taken = 1'b0;
    logic [31:0]      branch_addr = 32'd0;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_instr;
    logic             imem_ready = 1'b1;
    logic [31:0]      id_pc;
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             fetch_stall;
    logic [CNT_W-1:0] fetch_count;
    logic [CNT_W-1:0] miss_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] idpc;
        logic [31:0] instr;
        logic        valid;
        logic        stall;
        logic [31:0] fc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .imem_ready   (imem_ready),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .fetch_stall  (fetch_stall),
        .fetch_count  (fetch_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    // Memory image: each word is its address XOR a fixed tag.
    assign imem_instr = imem_addr ^ 32'hE1A0_0000;

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
        end
    endtask

    // Monitor: one expected record per clock edge, checked just after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "imem_addr",   imem_addr,          e.addr);
            chk(e.name, "id_pc",       id_pc,              e.idpc);
            chk(e.name, "id_instr",    id_instr,           e.instr);
            chk(e.name, "id_valid",    {31'd0, id_valid},  {31'd0, e.valid});
            chk(e.name, "fetch_stall", {31'd0, fetch_stall}, {31'd0, e.stall});
            chk(e.name, "fetch_count", fetch_count,        e.fc);
            chk(e.name, "miss_count",  miss_count,         e.mc);
        end
    end

    task automatic step(input string name, input logic r, input logic f,
                        input logic b, input logic [31:0] ba, input logic rdy,
                        input logic [31:0] e_addr, input logic [31:0] e_idpc,
                        input logic [31:0] e_instr, input logic e_v,
                        input logic [31:0] e_fc, input logic [31:0] e_mc);
        exp_t e;
        @(negedge clk);
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        imem_ready   = rdy;
        e.name  = name;
        e.addr  = e_addr;
        e.idpc  = e_idpc;
        e.instr = e_instr;
        e.valid = e_v;
        e.stall = ~rdy;
        e.fc    = e_fc;
        e.mc    = e_mc;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset with random side inputs
        for (int i = 0; i < 2; i++) begin
            step("reset", 1'b1, 1'($urandom), 1'($urandom), $urandom, 1'($urandom),
                 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
        end

        // Three advancing fetches
        step("adv0", 0, 0, 0, 0, 1, 32'h4, 32'h4, 32'hE1A0_0000, 1, 32'd1, 32'd0);
        step("adv1", 0, 0, 0, 0, 1, 32'h8, 32'h8, 32'hE1A0_0004, 1, 32'd2, 32'd0);
        step("adv2", 0, 0, 0, 0, 1, 32'hC, 32'hC, 32'hE1A0_0008, 1, 32'd3, 32'd0);

        // Freeze at pc=8 (second freeze cycle also misses: no miss counted)
        step("rst2",  1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 32'd0, 32'd0);
        step("pre0",  0, 0, 0, 0, 1, 32'h4, 32'h4, 32'hE1A0_0000, 1, 32'd1, 32'd0);
        step("pre1",  0, 0, 0, 0, 1, 32'h8, 32'h8, 32'hE1A0_0004, 1, 32'd2, 32'd0);
        step("frz0",  0, 1, 0, 0, 1, 32'h8, 32'h8, 32'hE1A0_0004, 1, 32'd2, 32'd0);
        step("frz1",  0, 1, 0, 0, 0, 32'h8, 32'h8, 32'hE1A0_0004, 1, 32'd2, 32'd0);
        step("unfrz", 0, 0, 0, 0, 1, 32'hC, 32'hC, 32'hE1A0_0008, 1, 32'd3, 32'd0);

        // Branch beats freeze and miss; low address bits dropped
        step("br93",  0, 1, 1, 32'h0000_0093, 0, 32'h90, 32'h0, 32'h0, 0, 32'd3, 32'd0);

        // Miss run at 0x20
        step("br20",  0, 0, 1, 32'h0000_0020, 1, 32'h20, 32'h0, 32'h0, 0, 32'd3, 32'd0);
        step("miss0", 0, 0, 0, 0, 0, 32'h20, 32'h0, 32'h0, 0, 32'd3, 32'd1);
        step("miss1", 0, 0, 0, 0, 0, 32'h20, 32'h0, 32'h0, 0, 32'd3, 32'd2);
        step("miss2", 0, 0, 0, 0, 0, 32'h20, 32'h0, 32'h0, 0, 32'd3, 32'd3);
        step("hit20", 0, 0, 0, 0, 1, 32'h24, 32'h24, 32'hE1A0_0020, 1, 32'd4, 32'd3);

        // PC wrap at top of address space
        step("brtop", 0, 0, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 32'd4, 32'd3);
        step("wrap",  0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h1E5F_FFFC, 1, 32'd5, 32'd3);

        // Reset in the middle of a miss delivers nothing stale
        step("mmiss", 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'd5, 32'd4);
        step("mrst",  1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 32'd0, 32'd0);
        step("post",  0, 0, 0, 0, 1, 32'h4, 32'h4, 32'hE1A0_0000, 1, 32'd1, 32'd0);

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d records unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
